// File: rtl/prog_clock_divider_pkg.sv
// Shared constants, types and helpers for the programmable clock divider.
package clk_div_pkg;

  localparam int          CNT_W        = 32;
  localparam int unsigned DEFAULT_HALF = 32'd5_000_000;

  // A single channel still needs a one-bit index so the config port stays uniform.
  function automatic int ch_idx_w(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

  typedef struct packed {
    logic [CNT_W-1:0] half;
    logic             pending;
  } ch_cfg_t;

endpackage

// File: rtl/prog_clock_divider_if.sv
// Config write port: valid/ready handshake plus a one-cycle error pulse.
interface prog_clock_divider_if
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = clk_div_pkg::CNT_W
);
  localparam int IDX_W = ch_idx_w(NUM_CH);

  logic             valid;
  logic [IDX_W-1:0] ch;
  logic [CNT_W-1:0] half;
  logic             ready;
  logic             err;

  modport master (output valid, ch, half, input ready, err);
  modport slave  (input valid, ch, half, output ready, err);
endinterface

// File: rtl/prog_clock_divider_channel.sv
// One divider channel: half-period counter, divided clock, tick, and a
// shadow half-period that takes effect only at a wrap or sync.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int               CNT_W        = clk_div_pkg::CNT_W,
  parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(clk_div_pkg::DEFAULT_HALF)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_enable,
  input  logic             i_sync,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_half,
  output logic             o_pending,
  output logic             o_clk,
  output logic             o_tick
);

  logic [CNT_W-1:0] half_q;
  logic [CNT_W-1:0] shadow_q;
  logic             pending_q;
  logic [CNT_W-1:0] cnt_q;
  logic             clk_q;
  logic             tick_q;
  logic             wrap;

  assign wrap = (cnt_q == (half_q - CNT_W'(1)));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      half_q    <= DEFAULT_HALF;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      cnt_q     <= '0;
      clk_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      if (i_enable && i_sync) begin
        cnt_q  <= '0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
        if (pending_q) begin
          half_q    <= shadow_q;
          pending_q <= 1'b0;
        end
      end else if (!i_enable) begin
        cnt_q  <= '0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else if (wrap) begin
        cnt_q  <= '0;
        clk_q  <= ~clk_q;
        tick_q <= 1'b1;
        if (pending_q) begin
          half_q    <= shadow_q;
          pending_q <= 1'b0;
        end
      end else begin
        cnt_q  <= cnt_q + CNT_W'(1);
        tick_q <= 1'b0;
      end
      // A load is only accepted while not pending, so it never races the apply above.
      if (i_load) begin
        if (i_enable) begin
          shadow_q  <= i_load_half;
          pending_q <= 1'b1;
        end else begin
          half_q <= i_load_half;
        end
      end
    end
  end

  assign o_pending = pending_q;
  assign o_clk     = clk_q;
  assign o_tick    = tick_q;

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider: config decode, ready mux and
// error flag around one clk_div_channel per output.
module prog_clock_divider
  import clk_div_pkg::*;
#(
  parameter int               NUM_CH       = 4,
  parameter int               CNT_W        = clk_div_pkg::CNT_W,
  parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(clk_div_pkg::DEFAULT_HALF)
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [NUM_CH-1:0] i_enable,
  input  logic              i_sync,
  prog_clock_divider_if.slave cfg,
  output logic [NUM_CH-1:0] o_clk,
  output logic [NUM_CH-1:0] o_tick
);

  localparam int IDX_W  = ch_idx_w(NUM_CH);
  localparam int PEND_W = 1 << IDX_W;

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] load;
  logic [PEND_W-1:0] pend_ext;
  logic              ready_c;
  logic              accept;
  logic              illegal;
  logic              err_q;

  // Indices past the last channel read as not pending, so they are always ready.
  always_comb begin
    pend_ext               = '0;
    pend_ext[NUM_CH-1:0]   = pending;
  end

  assign ready_c = ~pend_ext[cfg.ch];
  assign accept  = cfg.valid & ready_c;
  assign illegal = (cfg.half == '0) ||
                   ({{(32-IDX_W){1'b0}}, cfg.ch} >= 32'(NUM_CH));

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept & illegal;
    end
  end

  assign cfg.ready = ready_c;
  assign cfg.err   = err_q;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    assign load[n] = accept & ~illegal & (cfg.ch == IDX_W'(n));

    clk_div_channel #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .i_clk       (i_clk),
      .i_reset_n   (i_reset_n),
      .i_enable    (i_enable[n]),
      .i_sync      (i_sync),
      .i_load      (load[n]),
      .i_load_half (cfg.half),
      .o_pending   (pending[n]),
      .o_clk       (o_clk[n]),
      .o_tick      (o_tick[n])
    );
  end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Scoreboard bench for prog_clock_divider against a cycle-level behavioural model.
module tb_prog_clock_divider;
  import clk_div_pkg::*;

  localparam int NUM_CH = 3;
  localparam int HALF0  = 3;

  typedef struct {
    int                edge_n;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] clk;
    logic              err;
  } exp_t;

  logic              i_clk = 1'b0;
  logic              i_reset_n;
  logic [NUM_CH-1:0] en;
  logic              sync;
  logic [NUM_CH-1:0] o_clk;
  logic [NUM_CH-1:0] o_tick;

  prog_clock_divider_if #(.NUM_CH(NUM_CH), .CNT_W(32)) cfg_if ();

  prog_clock_divider #(
    .NUM_CH       (NUM_CH),
    .CNT_W        (32),
    .DEFAULT_HALF (32'(HALF0))
  ) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_enable  (en),
    .i_sync    (sync),
    .cfg       (cfg_if),
    .o_clk     (o_clk),
    .o_tick    (o_tick)
  );

  always #5 i_clk = ~i_clk;

  int   total = 0;
  int   bad   = 0;
  int   edge_n = 0;
  int   seen_n = 0;
  exp_t exp_q[$];
  exp_t me;

  ch_cfg_t     mcfg[NUM_CH];
  logic [31:0] mshadow[NUM_CH];
  int          ph[NUM_CH];
  logic        mclk[NUM_CH];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at edge %0d: got %0h want %0h", nm, edge_n, act, req);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < NUM_CH; n++) begin
      mcfg[n].half    = 32'(HALF0);
      mcfg[n].pending = 1'b0;
      mshadow[n]      = '0;
      ph[n]           = 0;
      mclk[n]         = 1'b0;
    end
  endtask

  task automatic apply_pending(input int n);
    if (mcfg[n].pending) begin
      mcfg[n].half    = mshadow[n];
      mcfg[n].pending = 1'b0;
    end
  endtask

  // Predict one clock edge from the current inputs, queue the expectation, advance.
  task automatic step();
    exp_t e;
    logic rdy, acc, ill;
    int   c;
    #1;
    c   = int'(cfg_if.ch);
    rdy = (c >= NUM_CH) ? 1'b1 : !mcfg[c].pending;
    chk("cfg_ready", 32'(cfg_if.ready), 32'(rdy));
    acc = cfg_if.valid && rdy;
    ill = (cfg_if.half == 0) || (c >= NUM_CH);
    for (int n = 0; n < NUM_CH; n++) begin
      e.tick[n] = 1'b0;
      if (en[n] && sync) begin
        ph[n] = 0; mclk[n] = 1'b0; apply_pending(n);
      end else if (!en[n]) begin
        ph[n] = 0; mclk[n] = 1'b0;
      end else begin
        ph[n]++;
        if (ph[n] == int'(mcfg[n].half)) begin
          ph[n] = 0; mclk[n] = !mclk[n]; e.tick[n] = 1'b1; apply_pending(n);
        end
      end
      e.clk[n] = mclk[n];
    end
    if (acc && !ill) begin
      if (en[c]) begin
        mshadow[c] = cfg_if.half; mcfg[c].pending = 1'b1;
      end else begin
        mcfg[c].half = cfg_if.half;
      end
    end
    e.err    = acc && ill;
    e.edge_n = edge_n + 1;
    exp_q.push_back(e);
    @(posedge i_clk);
    edge_n++;
    @(negedge i_clk);
  endtask

  task automatic write_cfg(input int ch, input int half);
    cfg_if.valid = 1'b1;
    cfg_if.ch    = 2'(ch);
    cfg_if.half  = 32'(half);
    step();
    cfg_if.valid = 1'b0;
  endtask

  always @(negedge i_clk) begin
    if (edge_n != seen_n) begin
      seen_n = edge_n;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard at edge %0d: no expectation queued", edge_n);
      end else begin
        me = exp_q.pop_front();
        chk("edge", 32'(edge_n), 32'(me.edge_n));
        chk("o_tick", 32'(o_tick), 32'(me.tick));
        chk("o_clk", 32'(o_clk), 32'(me.clk));
        chk("o_cfg_err", 32'(cfg_if.err), 32'(me.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset_n    = 1'b0;
    en           = '0;
    sync         = 1'b0;
    cfg_if.valid = 1'b0;
    cfg_if.ch    = '0;
    cfg_if.half  = '0;
    model_reset();
    repeat (3) @(negedge i_clk);
    chk("rst_o_clk", 32'(o_clk), 32'd0);
    chk("rst_o_tick", 32'(o_tick), 32'd0);
    chk("rst_err", 32'(cfg_if.err), 32'd0);
    chk("rst_ready", 32'(cfg_if.ready), 32'd1);

    // All channels run at the default half-period of 3.
    i_reset_n = 1'b1;
    en = '1;
    repeat (13) step();

    // Write ch0 on its wrap edge; that wrap still uses the old value.
    for (int i = 0; i < 10 && ph[0] != 2; i++) step();
    write_cfg(0, 5);
    repeat (16) step();

    // Illegal writes: zero half-period, then an out-of-range channel.
    write_cfg(1, 0);
    step();
    write_cfg(3, 4);
    repeat (3) step();

    // Disabled channel takes its new value immediately.
    en[2] = 1'b0;
    step();
    write_cfg(2, 2);
    step();
    en[2] = 1'b1;
    repeat (10) step();

    // Mixed periods, then a sync pulse to realign.
    write_cfg(0, 3);
    write_cfg(1, 4);
    repeat (11) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    repeat (12) step();

    // Reset mid-count with a write pending on ch0.
    write_cfg(0, 6);
    step();
    #2;
    i_reset_n = 1'b0;
    cfg_if.ch = '0;
    #1;
    chk("mid_rst_o_clk", 32'(o_clk), 32'd0);
    chk("mid_rst_o_tick", 32'(o_tick), 32'd0);
    chk("mid_rst_ready", 32'(cfg_if.ready), 32'd1);
    model_reset();
    repeat (2) @(negedge i_clk);
    i_reset_n = 1'b1;
    repeat (10) step();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      for (int n = 0; n < NUM_CH; n++) en[n] = ($urandom_range(0, 9) != 0);
      sync         = ($urandom_range(0, 19) == 0);
      cfg_if.valid = ($urandom_range(0, 3) == 0);
      cfg_if.ch    = 2'($urandom_range(0, 3));
      cfg_if.half  = 32'($urandom_range(0, 6));
      step();
    end
    cfg_if.valid = 1'b0;
    sync = 1'b0;
    repeat (4) step();

    #1;
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
